// File: rtl/mem_dma.sv
// mem_dma: single-port memory copy engine.
// Moves len words from src_addr to dst_addr, one word per RD/WR pair,
// in strictly ascending order with addresses wrapping modulo 2^ADDR_W.
// Optional feature: define MEM_DMA_FILL_EN to add the fill/fill_data
// inputs and a FILL state that writes a constant pattern, one word per cycle.
// All outputs are registered; each state's output values are loaded on the
// edge that enters that state.
module mem_dma #(
  parameter int BITS   = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
`ifdef MEM_DMA_FILL_EN
  input  logic              fill,
  input  logic [BITS-1:0]   fill_data,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_a,
  output logic [BITS-1:0]   mem_d,
  input  logic [BITS-1:0]   mem_q
);

`ifdef MEM_DMA_FILL_EN
  typedef enum logic [2:0] {IDLE, RD, WR, DONE, FILL} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, WR, DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W:0]   cnt;
  logic [BITS-1:0]   data_buf;

  // Transfer FSM: state, working addresses, remaining count, data buffer and
  // the registered memory-side outputs for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      cnt      <= '0;
      data_buf <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_wen  <= 1'b0;
      mem_a    <= '0;
      mem_d    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              // Empty request: straight to the completion pulse, no access.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              src  <= src_addr;
              dst  <= dst_addr;
              cnt  <= len;
              busy <= 1'b1;
`ifdef MEM_DMA_FILL_EN
              if (fill) begin
                // Fill pattern lives in the data buffer for the whole run.
                state    <= FILL;
                data_buf <= fill_data;
                mem_wen  <= 1'b1;
                mem_a    <= dst_addr;
                mem_d    <= fill_data;
              end else begin
                state   <= RD;
                mem_wen <= 1'b0;
                mem_a   <= src_addr;
              end
`else
              state   <= RD;
              mem_wen <= 1'b0;
              mem_a   <= src_addr;
`endif
            end
          end
        end

        RD: begin
          // Memory read is combinational; capture at the closing edge and
          // present it straight away as write data for the WR cycle.
          data_buf <= mem_q;
          state    <= WR;
          mem_wen  <= 1'b1;
          mem_a    <= dst;
          mem_d    <= mem_q;
        end

        WR: begin
          src <= src + ADDR_ONE;
          dst <= dst + ADDR_ONE;
          cnt <= cnt - CNT_ONE;
          mem_wen <= 1'b0;
          if (cnt > CNT_ONE) begin
            state <= RD;
            mem_a <= src + ADDR_ONE;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            mem_a <= '0;
          end
        end

`ifdef MEM_DMA_FILL_EN
        FILL: begin
          dst <= dst + ADDR_ONE;
          cnt <= cnt - CNT_ONE;
          if (cnt > CNT_ONE) begin
            mem_a <= dst + ADDR_ONE;
          end else begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            mem_wen <= 1'b0;
            mem_a   <= '0;
          end
        end
`endif

        DONE: begin
          // start is deliberately not looked at here.
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_wen <= 1'b0;
          mem_a   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: randomized scoreboard bench for mem_dma.
// A reference memory is updated word by word in ascending order for each
// request; the expected read addresses and write (address, data) pairs go
// into queues that a negedge monitor pops whenever the DUT accesses memory.
module tb_mem_dma;
  localparam int BITS   = 64;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_a;
  logic [BITS-1:0]   mem_d;
  logic [BITS-1:0]   mem_q;
`ifdef MEM_DMA_FILL_EN
  logic              fill;
  logic [BITS-1:0]   fill_data;
`endif

  logic [BITS-1:0] mem     [0:255];
  logic [BITS-1:0] ref_mem [0:255];
  logic            bd_we;
  logic [7:0]      bd_a;
  logic [BITS-1:0] bd_d;

  typedef struct {
    logic [7:0]      a;
    logic [BITS-1:0] d;
  } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];

  int checks = 0;
  int errors = 0;

  mem_dma #(.BITS(BITS), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
`ifdef MEM_DMA_FILL_EN
    .fill     (fill),
    .fill_data(fill_data),
`endif
    .busy     (busy),
    .done     (done),
    .mem_wen  (mem_wen),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at the posedge.
  assign mem_q = mem[mem_a];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_a] <= mem_d;
    else if (bd_we) mem[bd_a] <= bd_d;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every memory access the DUT makes must match the scoreboard.
  always @(negedge clk) begin
    if (mem_wen === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", {56'd0, mem_a}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("write_addr", {56'd0, mem_a}, {56'd0, e.a});
        chk("write_data", mem_d, e.d);
      end
    end else if (busy === 1'b1) begin
      if (rq.size() == 0) begin
        chk("unexpected_read_addr", {56'd0, mem_a}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [7:0] ea;
        ea = rq.pop_front();
        chk("read_addr", {56'd0, mem_a}, {56'd0, ea});
      end
    end
  end

  task automatic poke(input logic [7:0] a, input logic [BITS-1:0] d);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic cmp_mem(input string name);
    int bad;
    int first;
    bad = 0; first = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d words differ, first at %0h got %0h expected %0h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Reference behaviour: ascending word-at-a-time copy (or fill) on ref_mem.
  task automatic model(input logic [7:0] s, input logic [7:0] d, input int n,
                       input bit is_fill, input logic [BITS-1:0] fd);
    for (int i = 0; i < n; i++) begin
      logic [7:0]      sa;
      logic [7:0]      da;
      logic [BITS-1:0] v;
      sa = s + 8'(i);
      da = d + 8'(i);
      if (is_fill) begin
        v = fd;
      end else begin
        rq.push_back(sa);
        v = ref_mem[sa];
      end
      ref_mem[da] = v;
      wq.push_back('{a: da, d: v});
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] s, input logic [7:0] d, input int n,
                      input bit ign, input bit is_fill, input logic [BITS-1:0] fd);
    int cyc;
    int busy_cnt;
    int exp_done;
    bit seen;
    model(s, d, n, is_fill, fd);
    src_addr = s; dst_addr = d; len = 9'(n); start = 1'b1;
`ifdef MEM_DMA_FILL_EN
    fill = is_fill; fill_data = fd;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    exp_done = (n == 0) ? 1 : (is_fill ? n + 1 : 2 * n + 1);
    cyc = 1; busy_cnt = 0; seen = 1'b0;
    while (cyc <= 600) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (ign && cyc == 2) begin
        start = 1'b1; src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 9'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_done));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_done - 1));
    // A start during DONE must not launch anything.
    start = ign;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_width"}, 64'(done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_queues_empty"}, 64'(wq.size() + rq.size()), 64'd0);
    cmp_mem({tag, "_mem"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;
`ifdef MEM_DMA_FILL_EN
    fill = 1'b0; fill_data = '0;
`endif
    #1;
    for (int i = 0; i < 256; i++) poke(8'(i), {$urandom, $urandom});
    rst = 1'b0;
    chk("reset_busy",  64'(busy),    64'd0);
    chk("reset_done",  64'(done),    64'd0);
    chk("reset_wen",   64'(mem_wen), 64'd0);
    chk("reset_a",     64'(mem_a),   64'd0);
    chk("reset_d",     mem_d,        64'd0);

    // Directed copy of four known words.
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), 64'hA0 + 64'(i));
    xfer("basic", 8'h10, 8'h80, 4, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) chk("basic_word", mem[8'h80 + 8'(i)], 64'hA0 + 64'(i));

    // Zero length, address wrap, overlapping forward copy, ignored starts.
    xfer("len0",    8'h33, 8'h44, 0, 1'b0, 1'b0, '0);
    xfer("wrap",    8'hFE, 8'h01, 3, 1'b0, 1'b0, '0);
    xfer("overlap", 8'h40, 8'h42, 6, 1'b0, 1'b0, '0);
    xfer("ignore",  8'h60, 8'h90, 5, 1'b1, 1'b0, '0);

    // Reset during the second WR of a four-word copy: only words 0 and 1 land.
    model(8'hB0, 8'hC0, 2, 1'b0, '0);
    src_addr = 8'hB0; dst_addr = 8'hC0; len = 9'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_in_wr", 64'(mem_wen), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy),    64'd0);
    chk("abort_done", 64'(done),    64'd0);
    chk("abort_wen",  64'(mem_wen), 64'd0);
    chk("abort_a",    64'(mem_a),   64'd0);
    chk("abort_d",    mem_d,        64'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_queues_empty", 64'(wq.size() + rq.size()), 64'd0);
    cmp_mem("abort_mem");

    // Randomized copies, then a whole-memory copy.
    for (int t = 0; t < 8; t++) begin
      xfer("rand", 8'($urandom), 8'($urandom), int'($urandom_range(1, 24)), 1'($urandom), 1'b0, '0);
    end
    xfer("full", 8'($urandom), 8'($urandom), 256, 1'b0, 1'b0, '0);

`ifdef MEM_DMA_FILL_EN
    xfer("fill", 8'h20, 8'h20, 5, 1'b0, 1'b1, 64'hDEAD);
    for (int i = 0; i < 5; i++) chk("fill_word", mem[8'h20 + 8'(i)], 64'hDEAD);
    for (int t = 0; t < 4; t++) begin
      xfer("rand_fill", 8'($urandom), 8'($urandom), int'($urandom_range(1, 30)), 1'b0, 1'b1,
           {$urandom, $urandom});
    end
    xfer("copy_after_fill", 8'($urandom), 8'($urandom), 10, 1'b0, 1'b0, '0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
